// File: rtl/sub_pkg.sv
// Shared constants and pipeline-stage record for the 32-bit borrow-chained subtractor.
package sub_pkg;

  localparam int WIDTH  = 32;
  localparam int SLICE  = 8;
  localparam int NSTAGE = WIDTH / SLICE;

  typedef logic [SLICE-1:0] slice_t;

  // One pipeline slot: completed low bytes in done, operands still to be consumed in pa/pb.
  typedef struct packed {
    logic             valid;
    logic             carry;
    logic [WIDTH-1:0] done;
    logic [WIDTH-1:0] pa;
    logic [WIDTH-1:0] pb;
    logic             sa;
    logic             sb;
  } stage_s;

endpackage

// File: rtl/sub_slice_8bit.sv
// One byte of a - b computed as a + ~b + carry; carry out is the inverted borrow.
module sub_slice_8bit
  import sub_pkg::*;
(
  input  slice_t a_i,
  input  slice_t b_i,
  input  logic   cin_i,
  output slice_t d_o,
  output logic   cout_o
);

  assign {cout_o, d_o} = {1'b0, a_i} + {1'b0, ~b_i} + {{SLICE{1'b0}}, cin_i};

endmodule

// File: rtl/pipelined_subtractor_32bit.sv
// Four-stage valid/ready subtractor: one byte slice per stage, whole pipeline moves on a single enable.
module pipelined_subtractor_32bit #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        bin,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] diff,
  output logic        bout,
  output logic        ovf
);
  import sub_pkg::*;

  if (WIDTH != sub_pkg::WIDTH || SLICE != sub_pkg::SLICE) begin : g_width_check
    $error("pipelined_subtractor_32bit supports only WIDTH=32, SLICE=8");
  end

  logic                advance;
  stage_s              src   [NSTAGE];
  stage_s              stg_d [NSTAGE];
  stage_s              stg_q [NSTAGE];
  slice_t              d_w   [NSTAGE];
  logic   [NSTAGE-1:0] cout_w;

  // A stalled output freezes every stage, so in-flight slots never collide.
  assign advance  = ~stg_q[NSTAGE-1].valid | out_ready;
  assign in_ready = advance;

  always_comb begin
    src[0].valid = in_valid;
    src[0].carry = ~bin;
    src[0].done  = '0;
    src[0].pa    = a;
    src[0].pb    = b;
    src[0].sa    = a[31];
    src[0].sb    = b[31];
    for (int k = 1; k < NSTAGE; k++) begin
      src[k] = stg_q[k-1];
    end
  end

  for (genvar k = 0; k < NSTAGE; k++) begin : g_slice
    sub_slice_8bit u_slice (
      .a_i    (src[k].pa[k*SLICE +: SLICE]),
      .b_i    (src[k].pb[k*SLICE +: SLICE]),
      .cin_i  (src[k].carry),
      .d_o    (d_w[k]),
      .cout_o (cout_w[k])
    );
  end

  always_comb begin
    for (int k = 0; k < NSTAGE; k++) begin
      stg_d[k]                        = src[k];
      stg_d[k].done[k*SLICE +: SLICE] = d_w[k];
      stg_d[k].carry                  = cout_w[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NSTAGE; k++) begin
        stg_q[k] <= '0;
      end
    end else if (advance) begin
      stg_q <= stg_d;
    end
  end

  // Invalid slots carry stale data; mask it so idle outputs read as zero.
  assign out_valid = stg_q[NSTAGE-1].valid;
  assign diff      = out_valid ? stg_q[NSTAGE-1].done : '0;
  assign bout      = out_valid & ~stg_q[NSTAGE-1].carry;
  assign ovf       = out_valid & (stg_q[NSTAGE-1].sa ^ stg_q[NSTAGE-1].sb)
                               & (stg_q[NSTAGE-1].done[31] ^ stg_q[NSTAGE-1].sa);

endmodule

// File: tb/tb_pipelined_subtractor_32bit.sv
// Directed and streaming bench for pipelined_subtractor_32bit.
module tb_pipelined_subtractor_32bit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        bin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] diff;
  logic        bout;
  logic        ovf;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pipelined_subtractor_32bit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf)
  );

  // Reference result packed as {ovf, bout, diff}.
  function automatic logic [33:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                        input logic mbin);
    logic [32:0] full;
    logic [31:0] d;
    full = {1'b0, ma} - {1'b0, mb} - {32'b0, mbin};
    d    = full[31:0];
    return {(ma[31] != mb[31]) && (d[31] != ma[31]), full[32], d};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; bin = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_cmp++; if (diff !== 32'h0) begin n_bad++; $display("FAIL reset_diff: got %h expected 00000000", diff); end
    n_cmp++; if (bout !== 1'b0) begin n_bad++; $display("FAIL reset_bout: got %b expected 0", bout); end
    n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Presents one operation with out_ready high and checks latency and result.
  task automatic test_op(input string name, input logic [31:0] ta, input logic [31:0] tb_,
                         input logic tbin, input logic [31:0] ed, input logic eb, input logic eo);
    int lat;
    lat = 0;
    in_valid = 1'b1; a = ta; b = tb_; bin = tbin; out_ready = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (out_valid === 1'b1) begin lat = n; break; end
    end
    n_cmp++; if (lat != 4) begin n_bad++; $display("FAIL %s_latency: got %0d expected 4", name, lat); end
    n_cmp++; if (diff !== ed) begin n_bad++; $display("FAIL %s_diff: got %h expected %h", name, diff, ed); end
    n_cmp++; if (bout !== eb) begin n_bad++; $display("FAIL %s_bout: got %b expected %b", name, bout, eb); end
    n_cmp++; if (ovf !== eo) begin n_bad++; $display("FAIL %s_ovf: got %b expected %b", name, ovf, eo); end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    test_op("basic", 32'd5, 32'd3, 1'b0, 32'h00000002, 1'b0, 1'b0);
  endtask

  task automatic test_underflow();
    test_op("underflow", 32'h00000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0);
    test_op("signed_ovf", 32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1);
    test_op("neg_ovf", 32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h80000000, 1'b1, 1'b1);
  endtask

  task automatic test_borrow_chain();
    test_op("chain_byte1", 32'h00000100, 32'h00000000, 1'b1, 32'h000000FF, 1'b0, 1'b0);
    test_op("chain_all", 32'h00000000, 32'h00000000, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0);
  endtask

  // Streams nops operations; rnd selects random traffic, else the 1,0,0,1 out_ready pattern.
  task automatic test_stream(input string name, input bit rnd, input int nops, input int budget);
    logic [33:0] q[$];
    logic [33:0] exp;
    logic [31:0] held;
    logic        hold_prev;
    int          sent, got, cyc;
    sent = 0; got = 0; cyc = 0; hold_prev = 1'b0; held = '0;
    while (got < nops && cyc < budget) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : ((cyc % 4 == 0) || (cyc % 4 == 3));
      if (sent < nops && (!rnd || $urandom_range(0, 3) != 0)) begin
        in_valid = 1'b1;
        a   = rnd ? $urandom : sent * 32'h01010101;
        b   = rnd ? $urandom : 32'(sent);
        bin = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      end else begin
        in_valid = 1'b0;
        a = $urandom; b = $urandom; bin = 1'($urandom_range(0, 1));
      end
      #1;
      if (!rnd) begin
        n_cmp++;
        if (in_ready !== !(out_valid && !out_ready)) begin
          n_bad++; $display("FAIL %s_in_ready: got %b expected %b", name, in_ready, !(out_valid && !out_ready));
        end
        if (hold_prev) begin
          n_cmp++;
          if (out_valid !== 1'b1 || diff !== held) begin
            n_bad++; $display("FAIL %s_hold: got %b/%h expected 1/%h", name, out_valid, diff, held);
          end
        end
      end
      hold_prev = out_valid && !out_ready;
      held      = diff;
      if (out_valid === 1'b1 && out_ready) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++; $display("FAIL %s_extra: got result %h expected none", name, diff);
        end else begin
          exp = q.pop_front();
          if ({ovf, bout, diff} !== exp) begin
            n_bad++; $display("FAIL %s_result: got %h expected %h", name, {ovf, bout, diff}, exp);
          end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        q.push_back(model(a, b, bin));
        sent++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_cmp++; if (got != nops) begin n_bad++; $display("FAIL %s_count: got %0d expected %0d", name, got, nops); end
    n_cmp++; if (q.size() != 0) begin n_bad++; $display("FAIL %s_leftover: got %0d expected 0", name, q.size()); end
  endtask

  task automatic test_back_to_back();
    test_stream("stream", 1'b0, 8, 200);
  endtask

  task automatic test_random();
    test_stream("random", 1'b1, 10000, 60000);
  endtask

  task automatic test_reset_midflight();
    bit seen;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = 32'd100 + 32'(i); b = 32'(i); bin = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL rst_pre_valid: got %b expected 1", out_valid); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_async_valid: got %b expected 0", out_valid); end
    n_cmp++; if (diff !== 32'h0) begin n_bad++; $display("FAIL rst_async_diff: got %h expected 00000000", diff); end
    @(posedge clk); #1;
    rst_n = 1'b1; out_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    n_cmp++; if (seen) begin n_bad++; $display("FAIL rst_stale: got stale out_valid expected none"); end
    test_op("after_rst", 32'h00000010, 32'h00000001, 1'b0, 32'h0000000F, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_underflow();
    test_borrow_chain();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
